tx_arb: RTL and testbench

- Arbitrates the single UART transmit byte channel among three sources:
  - command-response bytes from the command configuration block;
  - 16-bit telemetry words from the flight controller, sent as two bytes;
  - an internally generated periodic heartbeat byte.
- Each source has a one-deep holding buffer.
- Sits between the command/telemetry logic and the UART transmitter; sequences trmt/tx_done handshakes so multi-byte frames are never interleaved.

---
 rtl/tx_arb_if.sv | 24 ++
 rtl/tx_arb.sv | 167 ++++++++++++++++
 tb/tb_tx_arb.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_arb_if.sv
// Byte-channel bundle shared by the request sources, the UART transmitter and tx_arb.
// The arbiter takes the slave view; whoever feeds requests and acknowledges bytes takes the master view.
interface tx_arb_if;
  logic        snd_rsp;
  logic [7:0]  resp;
  logic        tlm_vld;
  logic [15:0] tlm_data;
  logic        tx_done;
  logic        clr_ovr;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        busy;
  logic        rsp_ovr;

  modport master (
    output snd_rsp, resp, tlm_vld, tlm_data, tx_done, clr_ovr,
    input  trmt, tx_data, busy, rsp_ovr
  );

  modport slave (
    input  snd_rsp, resp, tlm_vld, tlm_data, tx_done, clr_ovr,
    output trmt, tx_data, busy, rsp_ovr
  );
endinterface

// File: rtl/tx_arb.sv
// Arbitrates the UART transmit byte channel among command responses, two-byte telemetry
// frames and a periodic heartbeat, each held in a one-deep buffer.
module tx_arb #(
  parameter int unsigned HB_PERIOD  = 1000000,
  parameter logic [7:0]  HB_BYTE    = 8'hA5,
  parameter int unsigned MAX_STREAK = 3
) (
  input logic     clk,
  input logic     rst,
  tx_arb_if.slave bus
);

  localparam int HB_W   = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  localparam int STRK_W = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam logic [HB_W-1:0]   HB_LAST  = HB_W'(HB_PERIOD - 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    SEND_B,
    WAIT_B,
    LOAD_LO
  } state_t;

  state_t            state;
  logic              rsp_pend;
  logic [7:0]        rsp_hold;
  logic              tlm_pend;
  logic [15:0]       tlm_hold;
  logic              hb_pend;
  logic [HB_W-1:0]   hb_cnt;
  logic [STRK_W-1:0] streak;
  logic              lo_next;
  logic [7:0]        tlm_lo;
  logic              trmt_q;
  logic [7:0]        tx_data_q;
  logic              busy_q;
  logic              rsp_ovr_q;

  logic idle;
  logic force_tlm;
  logic grant_rsp;
  logic grant_tlm;
  logic grant_hb;
  logic grant_any;
  logic hb_wrap;

  function automatic logic [STRK_W-1:0] sat_inc(input logic [STRK_W-1:0] v);
    return (v == STRK_MAX) ? v : v + 1'b1;
  endfunction

  // Grant decision on the registered pend flags; only meaningful while idle.
  always_comb begin
    idle      = (state == IDLE);
    force_tlm = tlm_pend && (streak == STRK_MAX);
    grant_tlm = idle && tlm_pend && (force_tlm || !rsp_pend);
    grant_rsp = idle && rsp_pend && !force_tlm;
    grant_hb  = idle && hb_pend && !rsp_pend && !tlm_pend;
    grant_any = grant_rsp || grant_tlm || grant_hb;
    hb_wrap   = (hb_cnt == HB_LAST);
  end

  // Holding buffers: a new request in the grant cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend  <= 1'b0;
      rsp_hold  <= 8'h00;
      tlm_pend  <= 1'b0;
      tlm_hold  <= 16'h0000;
      hb_pend   <= 1'b0;
      hb_cnt    <= '0;
      streak    <= '0;
      rsp_ovr_q <= 1'b0;
    end else begin
      if (bus.snd_rsp) begin
        rsp_pend <= 1'b1;
        rsp_hold <= bus.resp;
      end else if (grant_rsp) begin
        rsp_pend <= 1'b0;
      end

      if (bus.tlm_vld) begin
        tlm_pend <= 1'b1;
        tlm_hold <= bus.tlm_data;
      end else if (grant_tlm) begin
        tlm_pend <= 1'b0;
      end

      if (hb_wrap) begin
        hb_cnt  <= '0;
        hb_pend <= 1'b1;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
        if (grant_hb) hb_pend <= 1'b0;
      end

      if (grant_tlm)
        streak <= '0;
      else if (grant_rsp && tlm_pend)
        streak <= sat_inc(streak);

      if (bus.snd_rsp && rsp_pend && !grant_rsp)
        rsp_ovr_q <= 1'b1;
      else if (bus.clr_ovr)
        rsp_ovr_q <= 1'b0;
    end
  end

  // Transmit sequencer; LOAD_LO keeps the telemetry low byte at the same
  // two-cycle spacing after tx_done as a freshly arbitrated byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
      tx_data_q <= 8'h00;
      tlm_lo    <= 8'h00;
      lo_next   <= 1'b0;
    end else begin
      trmt_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_rsp) begin
            tx_data_q <= rsp_hold;
            lo_next   <= 1'b0;
          end else if (grant_tlm) begin
            tx_data_q <= tlm_hold[15:8];
            tlm_lo    <= tlm_hold[7:0];
            lo_next   <= 1'b1;
          end else if (grant_hb) begin
            tx_data_q <= HB_BYTE;
            lo_next   <= 1'b0;
          end
          if (grant_any) begin
            state  <= SEND_B;
            trmt_q <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        SEND_B: state <= WAIT_B;
        WAIT_B: begin
          if (bus.tx_done) begin
            if (lo_next) begin
              state     <= LOAD_LO;
              tx_data_q <= tlm_lo;
              lo_next   <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        LOAD_LO: begin
          state  <= SEND_B;
          trmt_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trmt    = trmt_q;
  assign bus.tx_data = tx_data_q;
  assign bus.busy    = busy_q;
  assign bus.rsp_ovr = rsp_ovr_q;

endmodule

// File: tb/tb_tx_arb.sv
// Self-checking bench for tx_arb: directed scenarios plus a randomized run scored
// against a transaction-level model of the arbitration rules.
module tb_tx_arb;
  localparam int         MAX_STREAK = 3;
  localparam logic [7:0] HB_BYTE    = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic rst_hb;
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  tx_arb_if bus();
  tx_arb_if hb_bus();

  tx_arb #(.HB_PERIOD(1000000), .HB_BYTE(HB_BYTE), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  tx_arb #(.HB_PERIOD(8), .HB_BYTE(HB_BYTE), .MAX_STREAK(MAX_STREAK)) dut_hb (
    .clk(clk), .rst(rst_hb), .bus(hb_bus)
  );

  always #5 clk = ~clk;

  // Reference model state: pending buffers, streak, overrun flag, owed low byte.
  bit          m_rp, m_tp, m_lo_pend, m_ovr;
  logic [7:0]  m_rv, m_lo;
  logic [15:0] m_tv;
  int          m_streak;
  logic [7:0]  strk_exp [0:11];
  logic [7:0]  strk_rsp [0:11];
  bit          strk_tlm [0:11];

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic clear_inputs();
    bus.snd_rsp = 1'b0; bus.resp = 8'h00; bus.tlm_vld = 1'b0; bus.tlm_data = 16'h0000;
    bus.tx_done = 1'b0; bus.clr_ovr = 1'b0;
  endtask

  task automatic model_reset();
    m_rp = 0; m_tp = 0; m_lo_pend = 0; m_ovr = 0;
    m_rv = 8'h00; m_lo = 8'h00; m_tv = 16'h0000; m_streak = 0;
  endtask

  task automatic model_apply(input bit do_r, input logic [7:0] rv, input bit do_t,
                             input logic [15:0] tv, input bit do_c);
    bit set_ovr;
    set_ovr = do_r && m_rp;
    if (do_r) begin m_rp = 1; m_rv = rv; end
    if (do_t) begin m_tp = 1; m_tv = tv; end
    if (set_ovr) m_ovr = 1;
    else if (do_c) m_ovr = 0;
  endtask

  task automatic model_arb(output bit any, output logic [7:0] b);
    any = 1'b1;
    b   = 8'h00;
    if (m_tp && (m_streak == MAX_STREAK || !m_rp)) begin
      b = m_tv[15:8]; m_lo = m_tv[7:0]; m_lo_pend = 1; m_tp = 0; m_streak = 0;
    end else if (m_rp) begin
      b = m_rv; m_rp = 0;
      if (m_tp && m_streak < MAX_STREAK) m_streak++;
    end else begin
      any = 1'b0;
    end
  endtask

  // Waits (bounded) for a trmt, returns its byte, injects requests in the first
  // WAIT_B cycle, then acknowledges gap cycles later; returns one cycle after tx_done.
  task automatic get_byte(input int gap, input bit do_r, input logic [7:0] rv, input bit do_t,
                          input logic [15:0] tv, input bit do_c,
                          output logic [7:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.trmt === 1'b1) begin ok = 1'b1; break; end
      cyc();
    end
    b = bus.tx_data;
    cyc();
    bus.snd_rsp = do_r; bus.resp = rv; bus.tlm_vld = do_t; bus.tlm_data = tv; bus.clr_ovr = do_c;
    cyc();
    bus.snd_rsp = 1'b0; bus.tlm_vld = 1'b0; bus.clr_ovr = 1'b0;
    repeat (gap) cyc();
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1;
    bus.snd_rsp = 1'b1; bus.resp = 8'h55; bus.tlm_vld = 1'b1; bus.tlm_data = 16'h5566;
    bus.tx_done = 1'b1; bus.clr_ovr = 1'b0;
    cyc(); cyc(); cyc();
    checks++; if (bus.trmt !== 1'b0) begin errors++; $display("FAIL reset_trmt: got %b want 0", bus.trmt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    checks++; if (bus.rsp_ovr !== 1'b0) begin errors++; $display("FAIL reset_rsp_ovr: got %b want 0", bus.rsp_ovr); end
    clear_inputs();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.trmt !== 1'b0 || bus.busy !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL reset_priority: got activity after reset want none"); end
  endtask

  task automatic test_basic_rsp();
    bit stable, seen;
    bus.resp = 8'h3C; bus.snd_rsp = 1'b1;
    cyc();
    bus.snd_rsp = 1'b0;
    checks++; if (bus.trmt !== 1'b0) begin errors++; $display("FAIL rsp_early_trmt: got %b want 0", bus.trmt); end
    cyc();
    checks++; if (bus.trmt !== 1'b1 || bus.tx_data !== 8'h3C || bus.busy !== 1'b1)
      begin errors++; $display("FAIL rsp_trmt_c2: got trmt=%b data=%h busy=%b want 1 3c 1", bus.trmt, bus.tx_data, bus.busy); end
    stable = 1;
    for (int c = 3; c <= 9; c++) begin
      cyc();
      if (bus.tx_data !== 8'h3C || bus.trmt !== 1'b0 || bus.busy !== 1'b1) stable = 0;
    end
    cyc();
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b0;
    checks++; if (!stable) begin errors++; $display("FAIL rsp_hold: got unstable data/trmt/busy want stable 3c"); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rsp_busy_c11: got %b want 0", bus.busy); end
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.trmt !== 1'b0 || bus.busy !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL stray_tx_done: got activity want none"); end
  endtask

  task automatic test_tlm_interleave();
    logic [7:0] b;
    bit ok;
    bus.tlm_data = 16'hBEEF; bus.tlm_vld = 1'b1;
    cyc();
    bus.tlm_vld = 1'b0;
    cyc();
    checks++; if (bus.trmt !== 1'b1 || bus.tx_data !== 8'hBE)
      begin errors++; $display("FAIL tlm_hi: got trmt=%b data=%h want 1 be", bus.trmt, bus.tx_data); end
    cyc();
    bus.resp = 8'h11; bus.snd_rsp = 1'b1;
    cyc();
    bus.snd_rsp = 1'b0;
    cyc();
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b0;
    checks++; if (bus.trmt !== 1'b0 || bus.busy !== 1'b1)
      begin errors++; $display("FAIL tlm_gap: got trmt=%b busy=%b want 0 1", bus.trmt, bus.busy); end
    cyc();
    checks++; if (bus.trmt !== 1'b1 || bus.tx_data !== 8'hEF)
      begin errors++; $display("FAIL tlm_lo: got trmt=%b data=%h want 1 ef", bus.trmt, bus.tx_data); end
    cyc(); cyc();
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b0;
    checks++; if (bus.trmt !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL tlm_end: got trmt=%b busy=%b want 0 0", bus.trmt, bus.busy); end
    cyc();
    checks++; if (bus.trmt !== 1'b1 || bus.tx_data !== 8'h11)
      begin errors++; $display("FAIL tlm_then_rsp: got trmt=%b data=%h want 1 11", bus.trmt, bus.tx_data); end
    get_byte(1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, b, ok);
  endtask

  task automatic test_streak();
    logic [7:0] b;
    bit ok;
    strk_exp = '{8'h01, 8'h02, 8'h03, 8'h12, 8'h34, 8'h04, 8'h05, 8'h06, 8'h07, 8'hAB, 8'hCD, 8'h08};
    strk_rsp = '{8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h00, 8'h00};
    strk_tlm = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    bus.resp = 8'h01; bus.snd_rsp = 1'b1; bus.tlm_data = 16'h1234; bus.tlm_vld = 1'b1;
    cyc();
    bus.snd_rsp = 1'b0; bus.tlm_vld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      get_byte(2, strk_rsp[i] != 8'h00, strk_rsp[i], strk_tlm[i], 16'hABCD, 1'b0, b, ok);
      checks++;
      if (!ok || b !== strk_exp[i])
        begin errors++; $display("FAIL streak_byte%0d: got %h (seen=%b) want %h", i, b, ok, strk_exp[i]); end
    end
    checks++; if (bus.rsp_ovr !== 1'b0) begin errors++; $display("FAIL streak_ovr: got %b want 0", bus.rsp_ovr); end
  endtask

  task automatic test_overwrite();
    logic [7:0] b;
    bit ok, seen;
    bus.resp = 8'h77; bus.snd_rsp = 1'b1;
    cyc();
    bus.snd_rsp = 1'b0;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.trmt === 1'b1) begin ok = 1; break; end
      cyc();
    end
    checks++; if (!ok || bus.tx_data !== 8'h77)
      begin errors++; $display("FAIL ovr_first: got %h (seen=%b) want 77", bus.tx_data, ok); end
    cyc();
    bus.resp = 8'hAA; bus.snd_rsp = 1'b1;
    cyc();
    bus.resp = 8'hBB;
    cyc();
    bus.snd_rsp = 1'b0;
    checks++; if (bus.rsp_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.rsp_ovr); end
    cyc();
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b0;
    get_byte(1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, b, ok);
    checks++; if (!ok || b !== 8'hBB) begin errors++; $display("FAIL ovr_byte: got %h (seen=%b) want bb", b, ok); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.trmt === 1'b1) seen = 1;
      cyc();
    end
    checks++; if (seen) begin errors++; $display("FAIL ovr_extra: got extra trmt want none"); end
    checks++; if (bus.rsp_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.rsp_ovr); end
    bus.clr_ovr = 1'b1;
    cyc();
    bus.clr_ovr = 1'b0;
    cyc();
    checks++; if (bus.rsp_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", bus.rsp_ovr); end
  endtask

  task automatic test_reset_midframe();
    bit ok, seen;
    bus.tlm_data = 16'h1234; bus.tlm_vld = 1'b1;
    cyc();
    bus.tlm_vld = 1'b0;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.trmt === 1'b1) begin ok = 1; break; end
      cyc();
    end
    checks++; if (!ok || bus.tx_data !== 8'h12)
      begin errors++; $display("FAIL mid_hi: got %h (seen=%b) want 12", bus.tx_data, ok); end
    cyc();
    bus.resp = 8'h01; bus.snd_rsp = 1'b1;
    cyc();
    bus.resp = 8'h02;
    cyc();
    bus.snd_rsp = 1'b0;
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b0;
    rst = 1'b1;
    cyc();
    checks++; if (bus.trmt !== 1'b0 || bus.busy !== 1'b0 || bus.tx_data !== 8'h00 || bus.rsp_ovr !== 1'b0)
      begin errors++; $display("FAIL mid_reset_out: got trmt=%b busy=%b data=%h ovr=%b want 0 0 00 0",
                               bus.trmt, bus.busy, bus.tx_data, bus.rsp_ovr); end
    rst = 1'b0;
    cyc(); cyc();
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.trmt !== 1'b0 || bus.busy !== 1'b0) seen = 1;
      cyc();
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_no_resume: got trmt/busy after reset want none"); end
  endtask

  task automatic test_random();
    bit inflight, any, ok, do_r, do_t, do_c;
    logic [7:0]  exp_b, b, rv;
    logic [15:0] tv;
    int r;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    model_reset();
    inflight = 0;
    exp_b = 8'h00;
    for (int it = 0; it < 80; it++) begin
      if (!inflight) begin
        r = int'($urandom_range(0, 2));
        do_r = (r != 1); do_t = (r != 0);
        rv = 8'($urandom); tv = 16'($urandom);
        bus.snd_rsp = do_r; bus.resp = rv; bus.tlm_vld = do_t; bus.tlm_data = tv;
        cyc();
        bus.snd_rsp = 1'b0; bus.tlm_vld = 1'b0;
        model_apply(do_r, rv, do_t, tv, 1'b0);
        model_arb(any, exp_b);
      end
      do_r = ($urandom_range(0, 1) == 1);
      do_t = ($urandom_range(0, 2) == 0);
      do_c = ($urandom_range(0, 4) == 0);
      rv = 8'($urandom); tv = 16'($urandom);
      get_byte(int'($urandom_range(1, 4)), do_r, rv, do_t, tv, do_c, b, ok);
      checks++;
      if (!ok || b !== exp_b)
        begin errors++; $display("FAIL rand_byte it=%0d: got %h (seen=%b) want %h", it, b, ok, exp_b); end
      model_apply(do_r, rv, do_t, tv, do_c);
      checks++;
      if (bus.rsp_ovr !== m_ovr)
        begin errors++; $display("FAIL rand_ovr it=%0d: got %b want %b", it, bus.rsp_ovr, m_ovr); end
      if (m_lo_pend) begin
        exp_b = m_lo; m_lo_pend = 0; inflight = 1;
      end else begin
        model_arb(any, exp_b);
        inflight = any;
      end
    end
  endtask

  task automatic test_heartbeat();
    bit ok, seen;
    int t_prev, t_now, d;
    rst_hb = 1'b0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (hb_bus.trmt === 1'b1) begin ok = 1; break; end
    end
    checks++; if (!ok || hb_bus.tx_data !== HB_BYTE)
      begin errors++; $display("FAIL hb_first: got %h (seen=%b) want a5", hb_bus.tx_data, ok); end
    t_prev = cyc_n;
    for (int k = 0; k < 2; k++) begin
      cyc();
      hb_bus.tx_done = 1'b1;
      cyc();
      hb_bus.tx_done = 1'b0;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        if (hb_bus.trmt === 1'b1) begin ok = 1; break; end
        cyc();
      end
      t_now = cyc_n;
      checks++; if (!ok || hb_bus.tx_data !== HB_BYTE || (t_now - t_prev) != 8)
        begin errors++; $display("FAIL hb_period%0d: got data=%h spacing=%0d want a5 8", k, hb_bus.tx_data, t_now - t_prev); end
      t_prev = t_now;
    end
    d = t_prev + 22;
    seen = 0;
    while (cyc_n < d) begin
      cyc();
      if (hb_bus.trmt === 1'b1 || hb_bus.busy !== 1'b1) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL hb_hold: got trmt or idle while held want busy"); end
    hb_bus.tx_done = 1'b1;
    cyc();
    hb_bus.tx_done = 1'b0;
    checks++; if (hb_bus.trmt !== 1'b0) begin errors++; $display("FAIL hb_arb_cycle: got %b want 0", hb_bus.trmt); end
    cyc();
    checks++; if (hb_bus.trmt !== 1'b1 || hb_bus.tx_data !== HB_BYTE)
      begin errors++; $display("FAIL hb_after_hold: got trmt=%b data=%h want 1 a5", hb_bus.trmt, hb_bus.tx_data); end
    cyc();
    hb_bus.tx_done = 1'b1;
    cyc();
    hb_bus.tx_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (hb_bus.trmt === 1'b1) seen = 1;
      cyc();
    end
    checks++; if (seen) begin errors++; $display("FAIL hb_queued: got second pending heartbeat want one"); end
    checks++; if (hb_bus.trmt !== 1'b1 || hb_bus.tx_data !== HB_BYTE)
      begin errors++; $display("FAIL hb_next_wrap: got trmt=%b data=%h want 1 a5", hb_bus.trmt, hb_bus.tx_data); end
  endtask

  initial begin
    rst = 1'b1;
    rst_hb = 1'b1;
    clear_inputs();
    hb_bus.snd_rsp = 1'b0; hb_bus.resp = 8'h00; hb_bus.tlm_vld = 1'b0; hb_bus.tlm_data = 16'h0000;
    hb_bus.tx_done = 1'b0; hb_bus.clr_ovr = 1'b0;
    test_reset();
    test_basic_rsp();
    test_tlm_interleave();
    test_streak();
    test_overwrite();
    test_reset_midframe();
    test_random();
    test_heartbeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
